game_flow_controller: RTL and testbench

Top-level game sequencer for the Pacman core. It owns the life count and level number and walks the game through attract, ready countdown, play, death, level-clear and game-over phases. It drives a freeze signal that halts sprite motion, plus respawn and level-up pulses that reposition sprites and reload the maze. It sits between the collision/pellet logic and the sprite, maze and HUD blocks, and all of its phase timing is counted in video frames.

---
 rtl/pacman_pkg.sv | 21 ++
 rtl/game_flow_controller_if.sv | 48 ++++
 rtl/game_flow_controller_timer.sv | 30 +++
 rtl/game_flow_controller.sv | 127 ++++++++++++
 tb/tb_game_flow_controller.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pacman_pkg.sv
// Shared types and defaults for the Pacman game core.
// Holds the game phase encoding and default frame counts.
package pacman_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    READY       = 3'd1,
    PLAY        = 3'd2,
    DYING       = 3'd3,
    LEVEL_CLEAR = 3'd4,
    GAME_OVER   = 3'd5
  } game_state_t;

  localparam int LIVES_INIT_DEF   = 2;
  localparam int READY_FRAMES_DEF = 120;
  localparam int DEATH_FRAMES_DEF = 90;
  localparam int CLEAR_FRAMES_DEF = 120;
  localparam int TIMER_W_DEF      = 8;
  localparam int LEVEL_W_DEF      = 4;

endpackage

// File: rtl/game_flow_controller_if.sv
// Game flow bus: event inputs from collision/pellet logic and
// phase/status outputs toward sprite, maze and HUD blocks.
interface game_flow_controller_if #(
  parameter int LEVEL_W = 4
);
  import pacman_pkg::*;

  logic               start;
  logic               frame_tick;
  logic               collision;
  logic               pellets_cleared;
  game_state_t        state;
  logic [1:0]         lives;
  logic [LEVEL_W-1:0] level;
  logic               freeze;
  logic               respawn;
  logic               level_up;
  logic               game_over;

  modport master (
    output start,
    output frame_tick,
    output collision,
    output pellets_cleared,
    input  state,
    input  lives,
    input  level,
    input  freeze,
    input  respawn,
    input  level_up,
    input  game_over
  );

  modport slave (
    input  start,
    input  frame_tick,
    input  collision,
    input  pellets_cleared,
    output state,
    output lives,
    output level,
    output freeze,
    output respawn,
    output level_up,
    output game_over
  );

endinterface

// File: rtl/game_flow_controller_timer.sv
// Frame countdown: loads a count, decrements per frame_tick,
// and flags the tick that consumes the last frame.
module frame_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clock,
  input  logic               Reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               frame_tick,
  output logic               done
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (frame_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // A tick during the load cycle is dropped, so N ticks follow entry.
  assign done = frame_tick && !load
             && (r_count == TIMER_W'(1));

endmodule

// File: rtl/game_flow_controller.sv
// Game sequencer: phase FSM, lives and level registers,
// respawn/level-up pulses and the sprite freeze decode.
module game_flow_controller
  import pacman_pkg::*;
#(
  parameter int LIVES_INIT   = LIVES_INIT_DEF,
  parameter int READY_FRAMES = READY_FRAMES_DEF,
  parameter int DEATH_FRAMES = DEATH_FRAMES_DEF,
  parameter int CLEAR_FRAMES = CLEAR_FRAMES_DEF,
  parameter int TIMER_W      = TIMER_W_DEF,
  parameter int LEVEL_W      = LEVEL_W_DEF
) (
  input logic                   clock,
  input logic                   Reset_n,
  game_flow_controller_if.slave bus
);

  game_state_t        r_state;
  game_state_t        w_next;
  logic [1:0]         r_lives;
  logic [1:0]         w_lives_next;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] w_level_next;
  logic               r_respawn;
  logic               w_respawn;
  logic               r_level_up;
  logic               w_level_up;
  logic               r_entry;
  logic [TIMER_W-1:0] w_load_value;
  logic               w_done;

  frame_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clock      (clock),
    .Reset_n    (Reset_n),
    .load       (r_entry),
    .load_value (w_load_value),
    .frame_tick (bus.frame_tick),
    .done       (w_done)
  );

  always_comb begin
    w_load_value = '0;
    unique case (r_state)
      READY:       w_load_value = TIMER_W'(READY_FRAMES);
      DYING:       w_load_value = TIMER_W'(DEATH_FRAMES);
      LEVEL_CLEAR: w_load_value = TIMER_W'(CLEAR_FRAMES);
      default:     w_load_value = '0;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    w_lives_next = r_lives;
    w_level_next = r_level;
    w_respawn    = 1'b0;
    w_level_up   = 1'b0;
    unique case (r_state)
      IDLE, GAME_OVER: begin
        if (bus.start) begin
          w_next       = READY;
          w_lives_next = 2'(LIVES_INIT);
          w_level_next = '0;
          w_respawn    = 1'b1;
        end
      end
      READY: begin
        if (w_done) w_next = PLAY;
      end
      PLAY: begin
        if (bus.pellets_cleared) begin
          w_next = LEVEL_CLEAR;
        end else if (bus.collision) begin
          w_next = DYING;
        end
      end
      DYING: begin
        if (w_done) begin
          if (r_lives == 2'd0) begin
            w_next = GAME_OVER;
          end else begin
            w_next       = READY;
            w_lives_next = r_lives - 2'd1;
            w_respawn    = 1'b1;
          end
        end
      end
      LEVEL_CLEAR: begin
        if (w_done) begin
          w_next     = READY;
          w_respawn  = 1'b1;
          w_level_up = 1'b1;
          if (r_level != '1) w_level_next = r_level + 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_lives    <= 2'(LIVES_INIT);
      r_level    <= '0;
      r_respawn  <= 1'b0;
      r_level_up <= 1'b0;
      r_entry    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_lives    <= w_lives_next;
      r_level    <= w_level_next;
      r_respawn  <= w_respawn;
      r_level_up <= w_level_up;
      r_entry    <= (w_next != r_state);
    end
  end

  assign bus.state     = r_state;
  assign bus.lives     = r_lives;
  assign bus.level     = r_level;
  assign bus.respawn   = r_respawn;
  assign bus.level_up  = r_level_up;
  assign bus.freeze    = (r_state != PLAY);
  assign bus.game_over = (r_state == GAME_OVER);

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed scenarios then random
// stimulus, all checked against a phase/tick-count reference model.
module tb_game_flow_controller;
  import pacman_pkg::*;

  localparam int RDY = 3;
  localparam int DTH = 2;
  localparam int CLR = 4;
  localparam int LVW = 2;
  localparam int LINIT = 2;

  logic clock;
  logic Reset_n;
  int   n_tests;
  int   n_fail;

  game_flow_controller_if #(.LEVEL_W(LVW)) bus ();

  game_flow_controller #(
    .LIVES_INIT   (LINIT),
    .READY_FRAMES (RDY),
    .DEATH_FRAMES (DTH),
    .CLEAR_FRAMES (CLR),
    .TIMER_W      (8),
    .LEVEL_W      (LVW)
  ) dut (
    .clock   (clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  game_state_t m_ph;
  int m_lives;
  int m_level;
  int m_age;
  int m_ticks;
  bit m_resp;
  bit m_lup;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph    = IDLE;
    m_lives = LINIT;
    m_level = 0;
    m_age   = 0;
    m_ticks = 0;
    m_resp  = 1'b0;
    m_lup   = 1'b0;
  endtask

  // Phase lengths in ticks; the tick on a phase's first cycle is dropped.
  task automatic model_step(input bit s, input bit t,
                            input bit c, input bit p);
    game_state_t nph;
    bit counted;
    int need;
    nph = m_ph;
    m_resp = 1'b0;
    m_lup = 1'b0;
    counted = t && (m_age > 0);
    need = (m_ph == READY) ? RDY :
           (m_ph == DYING) ? DTH : CLR;
    case (m_ph)
      IDLE, GAME_OVER:
        if (s) begin
          nph = READY;
          m_lives = LINIT;
          m_level = 0;
          m_resp = 1'b1;
        end
      READY:
        if (counted && m_ticks + 1 == need) nph = PLAY;
      PLAY:
        if (p) nph = LEVEL_CLEAR;
        else if (c) nph = DYING;
      DYING:
        if (counted && m_ticks + 1 == need) begin
          if (m_lives == 0) begin
            nph = GAME_OVER;
          end else begin
            m_lives = m_lives - 1;
            nph = READY;
            m_resp = 1'b1;
          end
        end
      LEVEL_CLEAR:
        if (counted && m_ticks + 1 == need) begin
          m_level = (m_level < (1 << LVW) - 1) ?
                    m_level + 1 : m_level;
          nph = READY;
          m_resp = 1'b1;
          m_lup = 1'b1;
        end
      default: nph = IDLE;
    endcase
    if (nph != m_ph) begin
      m_age = 0;
      m_ticks = 0;
    end else begin
      m_age++;
      if (counted) m_ticks++;
    end
    m_ph = nph;
  endtask

  task automatic check_all();
    chk("state", 32'(bus.state), 32'(m_ph));
    chk("lives", 32'(bus.lives), 32'(m_lives));
    chk("level", 32'(bus.level), 32'(m_level));
    chk("freeze", 32'(bus.freeze), 32'(m_ph != PLAY));
    chk("respawn", 32'(bus.respawn), 32'(m_resp));
    chk("level_up", 32'(bus.level_up), 32'(m_lup));
    chk("game_over", 32'(bus.game_over),
        32'(m_ph == GAME_OVER));
  endtask

  task automatic step(input bit s, input bit t,
                      input bit c, input bit p);
    bus.start = s;
    bus.frame_tick = t;
    bus.collision = c;
    bus.pellets_cleared = p;
    @(posedge clock);
    model_step(s, t, c, p);
    #1;
    check_all();
  endtask

  task automatic to_play();
    step(0, 1, 1, 1);
    repeat (RDY) step(0, 1, 0, 0);
  endtask

  task automatic die();
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    repeat (DTH) step(0, 1, 1, 0);
  endtask

  task automatic clear_level();
    step(0, 0, 1, 1);
    step(0, 1, 0, 0);
    repeat (CLR) step(0, 1, 1, 1);
  endtask

  task automatic async_reset();
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    Reset_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    Reset_n = 1'b0;
    bus.start = 1'b0;
    bus.frame_tick = 1'b0;
    bus.collision = 1'b0;
    bus.pellets_cleared = 1'b0;
    model_reset();
    #12;
    check_all();
    Reset_n = 1'b1;

    step(1, 0, 0, 0);
    chk("start_respawn", 32'(bus.respawn), 32'd1);
    to_play();
    chk("play_reached", 32'(bus.state), 32'(PLAY));
    chk("play_lives", 32'(bus.lives), 32'd2);

    die();
    chk("die1_lives", 32'(bus.lives), 32'd1);
    to_play();
    die();
    to_play();
    die();
    chk("go_state", 32'(bus.state), 32'(GAME_OVER));
    chk("go_lives", 32'(bus.lives), 32'd0);

    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (RDY) step(1, 1, 0, 0);
    chk("restart_play", 32'(bus.state), 32'(PLAY));
    repeat (4) begin
      clear_level();
      to_play();
    end
    chk("level_sat", 32'(bus.level), 32'd3);
    chk("clear_lives", 32'(bus.lives), 32'd2);

    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    async_reset();
    step(1, 0, 0, 0);
    chk("fresh_lives", 32'(bus.lives), 32'(LINIT));

    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 4) == 0,
           ($urandom % 3) == 0,
           ($urandom % 6) == 0,
           ($urandom % 14) == 0);
      if (($urandom % 600) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
